// File: rtl/uncached_wbuf_pkg.sv
// -----------------------------------------------------------------------------
// uncached_wbuf_pkg
// Shared data-bus types for the uncached access path:
//   dbus_req_t    - upstream uncached request bundle
//   wbuf_entry_t  - one posted-store entry (write, size, addr, wdata, strb)
//   wbuf_state_t  - bus sequencer states
//   entry_from_req - strips the valid bit off a request to form an entry
// -----------------------------------------------------------------------------
package uncached_wbuf_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } dbus_req_t;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } wbuf_entry_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    LD_ADDR = 3'd3,
    LD_DATA = 3'd4
  } wbuf_state_t;

  function automatic wbuf_entry_t entry_from_req(input dbus_req_t req);
    wbuf_entry_t e;
    e.write = req.write;
    e.size  = req.size;
    e.addr  = req.addr;
    e.wdata = req.wdata;
    e.strb  = req.strb;
    return e;
  endfunction

endpackage

// File: rtl/uncached_wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
// Posted-store FIFO of wbuf_entry_t. DEPTH must be a power of two so the
// pointers wrap modulo DEPTH by plain binary overflow.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   push, push_entry  - write an entry (ignored when full)
//   pop               - drop the head entry (ignored when empty)
//   full, empty       - occupancy flags from the registered count
//   head              - current head entry (combinational read)
//   count             - registered occupancy, clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module wbuf_fifo
  import uncached_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int COUNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  wbuf_entry_t        push_entry,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output wbuf_entry_t        head,
  output logic [COUNT_W-1:0] count
);

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               do_push;
  logic               do_pop;

  // Storage is tiny and the head must drive the bus in the same cycle the
  // sequencer enters ST_ADDR, so it is read asynchronously.
  wbuf_entry_t mem_reg [DEPTH];

  assign full    = (count_reg == COUNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + COUNT_W'(1);
        2'b01:   count_reg <= count_reg - COUNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: rtl/uncached_wbuf.sv
// -----------------------------------------------------------------------------
// uncached_wbuf
// Uncached access sequencer between the core data port and the uncached bus.
// At most one downstream transaction is ever outstanding.
//
// Build option UNCACHED_STORE_POST_EN:
//   defined   - stores are posted into a DEPTH-entry FIFO and acknowledged
//               (addr_ok + data_ok) combinationally in the cycle they are
//               pushed; loads wait until the FIFO has drained, so program
//               order is kept.
//   undefined - no FIFO; stores go straight to the bus like loads and are
//               acknowledged by the bus handshakes. DEPTH has no effect.
//
// Ports:
//   clk, reset                                 - clock, sync active-high reset
//   req_valid, req_write, req_size, req_addr,
//   req_wdata, req_strb                        - upstream request
//   resp_addr_ok, resp_data_ok, resp_rdata     - upstream response
//   bus_req, bus_write, bus_size, bus_addr,
//   bus_wdata, bus_strb                        - downstream request
//   bus_addr_ok, bus_data_ok, bus_rdata        - downstream response
//   busy                                       - FIFO non-empty or bus active
// -----------------------------------------------------------------------------
module uncached_wbuf
  import uncached_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_rdata,
  output logic        bus_req,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int COUNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  wbuf_state_t        state_reg;
  wbuf_state_t        state_next;
  dbus_req_t          up_req;
  wbuf_entry_t        live_entry;
  wbuf_entry_t        bus_entry;
  logic [COUNT_W-1:0] count;
  logic               store_pending;
  logic               load_pending;
  logic               addr_phase_ok;
  logic               data_phase_ok;
  logic               is_load;
  logic               load_data_ok;

  assign up_req = '{valid: req_valid, write: req_write, size: req_size,
                    addr: req_addr, wdata: req_wdata, strb: req_strb};
  assign live_entry   = entry_from_req(up_req);
  assign load_pending = up_req.valid & ~up_req.write;

  // Shared handshake decode. A data_ok seen while the address phase is still
  // open only counts when addr_ok arrives in the same cycle; otherwise it
  // cannot belong to anything we issued.
  assign addr_phase_ok = bus_req & bus_addr_ok;
  assign data_phase_ok = ((state_reg == ST_DATA || state_reg == LD_DATA) & bus_data_ok)
                       | (addr_phase_ok & bus_data_ok);
  assign is_load       = (state_reg == LD_ADDR) || (state_reg == LD_DATA);
  assign load_data_ok  = is_load & data_phase_ok;
  assign resp_rdata    = load_data_ok ? bus_rdata : '0;

`ifdef UNCACHED_STORE_POST_EN
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  wbuf_entry_t fifo_head;

  // Full is judged on the registered count only: a pop in this cycle does
  // not free a slot until the next one. A push is also held off in the cycle
  // a load returns data so the single resp_data_ok pulse is never ambiguous,
  // and during reset so no store is acknowledged and then thrown away.
  assign push = req_valid & req_write & ~fifo_full & ~reset & ~load_data_ok;
  assign pop  = (state_reg == ST_ADDR) & bus_addr_ok;

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (live_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .count      (count)
  );

  assign store_pending = ~fifo_empty;
  assign bus_entry     = (state_reg == ST_ADDR) ? fifo_head : live_entry;
  assign resp_addr_ok  = push | (is_load & addr_phase_ok);
  assign resp_data_ok  = push | load_data_ok;
`else
  assign count         = '0;
  assign store_pending = up_req.valid & up_req.write;
  assign bus_entry     = live_entry;
  assign resp_addr_ok  = addr_phase_ok;
  assign resp_data_ok  = data_phase_ok;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bus_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Queued stores go first so a load never overtakes an older store.
        if (store_pending)     state_next = ST_ADDR;
        else if (load_pending) state_next = LD_ADDR;
      end
      ST_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) state_next = bus_data_ok ? IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bus_data_ok) state_next = IDLE;
      end
      LD_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) state_next = bus_data_ok ? IDLE : LD_DATA;
      end
      LD_DATA: begin
        if (bus_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_write = bus_req & bus_entry.write;
  assign bus_size  = bus_entry.size;
  assign bus_addr  = bus_entry.addr;
  assign bus_wdata = bus_entry.wdata;
  assign bus_strb  = bus_entry.strb;

  assign busy = (count != '0) | (state_reg != IDLE);

endmodule

// File: tb/tb_uncached_wbuf.sv
// -----------------------------------------------------------------------------
// tb_uncached_wbuf
// Directed bench for uncached_wbuf. Posting scenarios are compiled when
// UNCACHED_STORE_POST_EN is defined; the direct-store scenario otherwise.
// Inputs change 1 time unit after the rising edge, outputs are sampled 2-3
// units later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_uncached_wbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [31:0] resp_rdata;
  logic        bus_req;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uncached_wbuf #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_strb     (req_strb),
    .resp_addr_ok (resp_addr_ok),
    .resp_data_ok (resp_data_ok),
    .resp_rdata   (resp_rdata),
    .bus_req      (bus_req),
    .bus_write    (bus_write),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_strb     (bus_strb),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_addr    = '0;
    req_wdata   = '0;
    req_strb    = 4'hF;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
    checks++; if (resp_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got %b exp 0", resp_addr_ok); end
    checks++; if (resp_data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got %b exp 0", resp_data_ok); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
    $display("reset: bus_req=%b busy=%b", bus_req, busy);
    tick();
  endtask

  // Load with a one-cycle wait on addr_ok, data one cycle after addr_ok.
  task automatic test_load();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hBFD0_F010;
    tick();                                   // now LD_ADDR
    #2;
    checks++; if (bus_req !== 1'b1 || bus_write !== 1'b0) begin errors++; $display("FAIL ld_bus_req got req=%b wr=%b exp 1/0", bus_req, bus_write); end
    checks++; if (bus_addr !== 32'hBFD0_F010) begin errors++; $display("FAIL ld_bus_addr got %h exp bfd0f010", bus_addr); end
    checks++; if (resp_addr_ok !== 1'b0) begin errors++; $display("FAIL ld_early_ack got %b exp 0", resp_addr_ok); end
    tick();
    bus_addr_ok = 1'b1;
    #2;
    checks++; if (resp_addr_ok !== 1'b1 || resp_data_ok !== 1'b0) begin errors++; $display("FAIL ld_addr_ack got a=%b d=%b exp 1/0", resp_addr_ok, resp_data_ok); end
    tick();                                   // now LD_DATA
    req_valid = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #2;
    checks++; if (resp_data_ok !== 1'b1) begin errors++; $display("FAIL ld_data_ok got %b exp 1", resp_data_ok); end
    checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata got %h exp deadbeef", resp_rdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld_busy got %b exp 1", busy); end
    $display("load addr=bfd0f010 rdata=%h", resp_rdata);
    tick();
    bus_data_ok = 1'b0; bus_rdata = '0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld_idle_busy got %b exp 0", busy); end
    tick();
  endtask

  // addr_ok and data_ok in the same cycle finish the load at once.
  task automatic test_same_cycle();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hBFD0_F020;
    tick();                                   // LD_ADDR
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_F00D;
    #2;
    checks++; if (resp_addr_ok !== 1'b1 || resp_data_ok !== 1'b1) begin errors++; $display("FAIL sc_acks got a=%b d=%b exp 1/1", resp_addr_ok, resp_data_ok); end
    checks++; if (resp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL sc_rdata got %h exp 0badf00d", resp_rdata); end
    $display("load addr=bfd0f020 same-cycle rdata=%h", resp_rdata);
    tick();
    clear_inputs();
    #2;
    checks++; if (busy !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL sc_idle got busy=%b req=%b exp 0/0", busy, bus_req); end
    tick();
  endtask

  // Reset while a load is in its data phase (with stores queued when posting).
  task automatic test_reset_in_ld_data();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hBFD0_F030;
    tick();                                   // LD_ADDR
    bus_addr_ok = 1'b1;
    tick();                                   // LD_DATA
    bus_addr_ok = 1'b0;
    req_valid = 1'b0;
`ifdef UNCACHED_STORE_POST_EN
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 32'h1FD0_F100 + 32'(4 * i); req_wdata = 32'h5500_0000 + 32'(i);
      #2;
      checks++; if (resp_addr_ok !== 1'b1) begin errors++; $display("FAIL rst_q_push%0d got %b exp 1", i, resp_addr_ok); end
      tick();
    end
    req_valid = 1'b0; req_write = 1'b0;
`endif
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_ld_busy got %b exp 0", busy); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_ld_bus_req got %b exp 0", bus_req); end
    bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    checks++; if (resp_data_ok !== 1'b0) begin errors++; $display("FAIL rst_late_data_ok got %b exp 0", resp_data_ok); end
    $display("reset in LD_DATA: busy=%b late data_ok ignored=%b", busy, ~resp_data_ok);
    tick();
    clear_inputs();
    tick();
  endtask

`ifdef UNCACHED_STORE_POST_EN
  // Four posted stores, bus acking every phase immediately.
  task automatic test_posted_stores();
    int nwr = 0;
    int cyc = 0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 32'h1FD0_F000 + 32'(4 * i); req_wdata = 32'hA000_0000 + 32'(i);
      #2;
      checks++; if (resp_addr_ok !== 1'b1 || resp_data_ok !== 1'b1) begin errors++; $display("FAIL post_ack%0d got a=%b d=%b exp 1/1", i, resp_addr_ok, resp_data_ok); end
      if (bus_req === 1'b1 && bus_write === 1'b1) begin
        checks++; if (bus_addr !== 32'h1FD0_F000 + 32'(4 * nwr)) begin errors++; $display("FAIL post_order%0d got %h exp %h", nwr, bus_addr, 32'h1FD0_F000 + 32'(4 * nwr)); end
        nwr++;
      end
      $display("store addr=%h ack=%b", req_addr, resp_addr_ok);
      tick();
    end
    req_valid = 1'b0; req_write = 1'b0;
    while (busy === 1'b1 && cyc < 30) begin
      #2;
      if (bus_req === 1'b1 && bus_write === 1'b1) begin
        checks++; if (bus_addr !== 32'h1FD0_F000 + 32'(4 * nwr)) begin errors++; $display("FAIL post_order%0d got %h exp %h", nwr, bus_addr, 32'h1FD0_F000 + 32'(4 * nwr)); end
        nwr++;
      end
      tick();
      cyc++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_drain_busy got %b exp 0", busy); end
    checks++; if (nwr != 4) begin errors++; $display("FAIL post_write_count got %0d exp 4", nwr); end
    clear_inputs();
    tick();
  endtask

  // Five stores with the bus stalled: the fifth waits for the first pop.
  task automatic test_fifo_full();
    int cyc = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1FD0_F000 + 32'(4 * i);
      #2;
      checks++; if (resp_addr_ok !== 1'b1) begin errors++; $display("FAIL full_push%0d got %b exp 1", i, resp_addr_ok); end
      tick();
    end
    req_addr = 32'h1FD0_F010;
    for (int j = 0; j < 2; j++) begin
      #2;
      checks++; if (resp_addr_ok !== 1'b0) begin errors++; $display("FAIL full_stall%0d got %b exp 0", j, resp_addr_ok); end
      tick();
    end
    bus_addr_ok = 1'b1;
    #2;
    checks++; if (resp_addr_ok !== 1'b0) begin errors++; $display("FAIL full_no_bypass got %b exp 0", resp_addr_ok); end
    checks++; if (bus_addr !== 32'h1FD0_F000) begin errors++; $display("FAIL full_head got %h exp 1fd0f000", bus_addr); end
    tick();
    bus_addr_ok = 1'b0;
    #2;
    checks++; if (resp_addr_ok !== 1'b1) begin errors++; $display("FAIL full_after_pop got %b exp 1", resp_addr_ok); end
    $display("store addr=1fd0f010 accepted after first pop");
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    while (busy === 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain got %b exp 0", busy); end
    clear_inputs();
    tick();
  endtask

  // Two stores then a load: the load completes only after both writes.
  task automatic test_store_then_load();
    int nwr = 0;
    int cyc = 0;
    bit done = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1FD0_F000 + 32'(4 * i);
      #2;
      if (bus_req === 1'b1 && bus_write === 1'b1) nwr++;
      tick();
    end
    req_write = 1'b0; req_addr = 32'hBFD0_F010;
    while (!done && cyc < 20) begin
      #2;
      if (bus_req === 1'b1 && bus_write === 1'b1) nwr++;
      if (resp_data_ok === 1'b1) begin
        done = 1'b1;
        checks++; if (nwr != 2) begin errors++; $display("FAIL stld_order got %0d writes exp 2", nwr); end
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stld_rdata got %h exp deadbeef", resp_rdata); end
        $display("load addr=bfd0f010 rdata=%h after %0d writes", resp_rdata, nwr);
      end
      tick();
      cyc++;
    end
    checks++; if (!done) begin errors++; $display("FAIL stld_timeout got no data_ok exp data_ok"); end
    clear_inputs();
    tick();
  endtask
`else
  // Direct store with a 3-cycle data latency after addr_ok.
  task automatic test_store_direct();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1FD0_F000; req_wdata = 32'hCAFE_0001;
    #2;
    checks++; if (resp_addr_ok !== 1'b0) begin errors++; $display("FAIL st_idle_ack got %b exp 0", resp_addr_ok); end
    tick();                                   // ST_ADDR
    #2;
    checks++; if (bus_req !== 1'b1 || bus_write !== 1'b1) begin errors++; $display("FAIL st_bus_req got req=%b wr=%b exp 1/1", bus_req, bus_write); end
    checks++; if (bus_addr !== 32'h1FD0_F000 || bus_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL st_bus_fields got %h/%h exp 1fd0f000/cafe0001", bus_addr, bus_wdata); end
    bus_addr_ok = 1'b1;
    #1;
    checks++; if (resp_addr_ok !== 1'b1 || resp_data_ok !== 1'b0) begin errors++; $display("FAIL st_addr_ack got a=%b d=%b exp 1/0", resp_addr_ok, resp_data_ok); end
    tick();                                   // ST_DATA
    bus_addr_ok = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_data_ok = (i == 2);
      #2;
      checks++; if (resp_data_ok !== (i == 2)) begin errors++; $display("FAIL st_data_ok%0d got %b exp %b", i, resp_data_ok, (i == 2)); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL st_data_bus_req%0d got %b exp 0", i, bus_req); end
      tick();
    end
    bus_data_ok = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL st_done_busy got %b exp 0", busy); end
    $display("store addr=1fd0f000 completed with bus data_ok");
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef UNCACHED_STORE_POST_EN
    test_posted_stores();
    test_fifo_full();
    test_store_then_load();
`else
    test_store_direct();
`endif
    test_load();
    test_same_cycle();
    test_reset_in_ld_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/uncached_wbuf.md
UNCACHED_WBUF -- requirements
Module: uncached_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning store-FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid/req_write  input  1/1  upstream uncached request and its direction.
REQ-005 SHALL have ports req_size, req_addr, req_wdata, req_strb  input  2/32/32/4  size code, physical address, store data, byte strobe.
REQ-006 SHALL have ports resp_addr_ok, resp_data_ok  output  1/1  upstream request accepted / data returned.
REQ-007 SHALL have port resp_rdata  output  32  load data, valid with resp_data_ok.
REQ-008 SHALL have ports bus_req, bus_write, bus_size, bus_addr, bus_wdata, bus_strb  output  1/1/2/32/32/4  downstream uncached bus request.
REQ-009 SHALL have ports bus_addr_ok, bus_data_ok, bus_rdata  input  1/1/32  downstream handshake and load data.
REQ-010 SHALL have port busy  output  1  FIFO non-empty or downstream transaction outstanding.

Function
REQ-011 Upstream store SHALL be posted: when req_valid & req_write & count<DEPTH, push entry and assert resp_addr_ok and resp_data_ok combinationally in the same cycle.
REQ-012 Store with count==DEPTH SHALL see both acks low; push uses registered count, no same-cycle pop bypass.
REQ-013 Upstream load SHALL be accepted only when count==0 and FSM in IDLE; it is then forwarded on the bus, preserving program order behind all posted stores.
REQ-014 FSM states SHALL be IDLE, ST_ADDR, ST_DATA, LD_ADDR, LD_DATA.
REQ-015 IDLE: count>0 -> ST_ADDR; else load pending -> LD_ADDR; stores take priority.
REQ-016 ST_ADDR: bus_req=1, bus_write=1, head entry driven; bus_addr_ok -> ST_DATA, pop head.
REQ-017 ST_DATA: bus_req=0; bus_data_ok -> IDLE. At most one downstream transaction outstanding.
REQ-018 LD_ADDR: bus_req=1, bus_write=0, fields from live req_*; resp_addr_ok=bus_addr_ok; bus_addr_ok -> LD_DATA.
REQ-019 LD_DATA: resp_data_ok=bus_data_ok, resp_rdata=bus_rdata; bus_data_ok -> IDLE. Upstream holds req stable until addr_ok.
REQ-020 bus_addr_ok and bus_data_ok in the same cycle SHALL return the FSM directly to IDLE.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-022 busy SHALL equal (count!=0) | (state!=IDLE).

Reset
REQ-023 On reset: state=IDLE, count=0, pointers=0; next cycle bus_req=0, resp_addr_ok=0, resp_data_ok=0, busy=0, resp_rdata=0.
REQ-024 Reset during ST_DATA/LD_DATA SHALL discard the outstanding transaction and queued stores; late bus_data_ok is ignored.

Configuration
REQ-025 Macro UNCACHED_STORE_POST_EN: defined -> posting per REQ-011..012.
REQ-026 Undefined -> no FIFO; stores handled like loads via states ST_ADDR/ST_DATA with resp_addr_ok=bus_addr_ok, resp_data_ok=bus_data_ok; DEPTH ignored.

Structure
REQ-027 Entry struct (write, size, addr, wdata, strb) and FSM state enum SHALL live in the shared data bus package beside dbus_req_t.
REQ-028 FIFO storage SHALL be one sub-module, wbuf_fifo (push/pop/full/empty/head).

Verification
REQ-029 Reset, then 4 stores to 0x1FD0_F000..0x1FD0_F00C with 1-cycle bus handshakes -> 4 immediate acks, bus writes in same order, busy drops after last bus_data_ok.
REQ-030 5 back-to-back stores with bus_addr_ok held low -> 5th store sees resp_addr_ok=0 until first pop.
REQ-031 2 stores then load of 0xBFD0_F010 -> load acked only after both bus writes finish; resp_rdata=0xDEAD_BEEF from bus.
REQ-032 Load with bus_addr_ok and bus_data_ok in same cycle -> resp_data_ok that cycle, FSM IDLE next cycle.
REQ-033 Reset asserted in LD_DATA with 3 stores queued -> next cycle busy=0, bus_req=0; subsequent bus_data_ok produces no resp_data_ok.
REQ-034 Build without UNCACHED_STORE_POST_EN, store with 3-cycle bus latency -> resp_data_ok exactly with bus_data_ok.
